// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter and its
// priority encoder.
package pkt_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

   localparam int N_REQ_MAX = 16;

   // Index width for n channels; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder: returns the first set request at
// or after ptr_i, wrapping past the top index back to zero.
module rr_pick
   import pkt_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]          req_i,
   input  logic [idx_w(N_REQ)-1:0]   ptr_i,
   output logic                      any_o,
   output logic [idx_w(N_REQ)-1:0]   idx_o
);

   localparam int IW = idx_w(N_REQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

   logic [IW-1:0] cand;

   // Explicit compare against the top index keeps the wrap correct when
   // N_REQ is not a power of two.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      cand  = ptr_i;
      for (int k = 0; k < N_REQ; k++) begin
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      end
   end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Packet-locked round-robin arbiter: N_REQ valid/ready streams share one
// output channel; a grant is held from first beat until the last beat.
module pkt_rr_arbiter
   import pkt_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          s_valid,
   input  logic [N_REQ*DATA_W-1:0]   s_data,
   input  logic [N_REQ-1:0]          s_last,
   output logic [N_REQ-1:0]          s_ready,
   output logic                      m_valid,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic [idx_w(N_REQ)-1:0]   m_src,
   input  logic                      m_ready,
   output logic                      busy,
   output logic [CNT_W-1:0]          pkt_cnt
);

   localparam int IW = idx_w(N_REQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

   if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
      $error("pkt_rr_arbiter: N_REQ out of range");
   end

   arb_state_e     state_q, state_d;
   logic [IW-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           pick_any;
   logic [IW-1:0]  pick_idx;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i (s_valid),
      .ptr_i (ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   assign pkt_cnt = cnt_q;

   // Handshake: a beat moves on the cycle m_valid && m_ready are both high;
   // the granted source sees s_ready = m_ready, every other source sees 0.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      s_ready = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_last  = 1'b0;
      m_src   = '0;
      busy    = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            busy           = 1'b1;
            m_valid        = s_valid[gnt_q];
            m_data         = s_data[gnt_q*DATA_W +: DATA_W];
            m_last         = s_last[gnt_q];
            m_src          = gnt_q;
            s_ready[gnt_q] = m_ready;
            // Pointer only moves on packet completion, never per beat.
            if (m_valid && m_ready && m_last) begin
               state_d = ARB_IDLE;
               ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: inputs change on the falling edge and
// outputs are compared 1 ns later, against hand-computed per-cycle tables.
module tb_pkt_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    s_valid, s_last, s_ready;
   logic [N*DW-1:0] s_data;
   logic            m_valid, m_last, m_ready, busy;
   logic [DW-1:0]   m_data;
   logic [1:0]      m_src;
   logic [CW-1:0]   pkt_cnt;

   int           len[N], plen[N], pos[N];
   logic         hold[N];
   logic [DW-1:0] base[N];
   int           n_vec = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   pkt_rr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_src   (m_src),
      .m_ready (m_ready),
      .busy    (busy),
      .pkt_cnt (pkt_cnt)
   );

   // Requester i sends len[i] beats, data base[i]+beat, last every plen[i].
   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         len[i]  = 0;
         plen[i] = 1;
         pos[i]  = 0;
         hold[i] = 1'b0;
         base[i] = 32'hA0 + 32'(i * 16);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         s_valid[i] = (pos[i] < len[i]) && !hold[i];
         s_last[i]  = ((pos[i] % plen[i]) == plen[i] - 1);
         s_data[i*DW +: DW] = base[i] + 32'(pos[i]);
      end
      #1;
   endtask

   task automatic advance();
      for (int i = 0; i < N; i++)
         if (s_valid[i] && s_ready[i]) pos[i]++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      m_ready = 1'b1;
      clear_model();
      apply();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      m_ready = 1'b1;
      clear_model();
      for (int i = 0; i < N; i++) len[i] = 1;
      apply();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
      n_vec++; if (s_ready !== 4'b0000) begin n_err++; $display("FAIL rst_s_ready got %b want 0000", s_ready); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_vec++; if (pkt_cnt !== 4'd0) begin n_err++; $display("FAIL rst_pkt_cnt got %0d want 0", pkt_cnt); end
      n_vec++; if (m_src !== 2'd0 || m_last !== 1'b0 || m_data !== 32'h0) begin
         n_err++; $display("FAIL rst_m_fields got src=%0d last=%b data=%h want 0/0/0", m_src, m_last, m_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_rel_c1 got m_valid=%b want 0", m_valid); end
      advance();
      apply();
      n_vec++; if (m_valid !== 1'b1 || m_src !== 2'd0) begin
         n_err++; $display("FAIL rst_rel_c2 got valid=%b src=%0d want 1/0", m_valid, m_src);
      end
      advance();
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) begin len[i] = 2; plen[i] = 2; end
      for (int k = 0; k < 13; k++) begin
         int grp, ph;
         grp = k / 3;
         ph  = k % 3;
         apply();
         n_vec++; if (m_valid !== (ph != 0) || busy !== (ph != 0)) begin
            n_err++; $display("FAIL rr_valid c%0d got v=%b b=%b want %b", k, m_valid, busy, ph != 0);
         end
         if (ph != 0) begin
            n_vec++;
            if (m_src !== 2'(grp) || m_data !== 32'hA0 + 32'(grp*16 + ph - 1) || m_last !== (ph == 2)) begin
               n_err++; $display("FAIL rr_beat c%0d got src=%0d data=%h last=%b want %0d/%h/%b",
                  k, m_src, m_data, m_last, grp, 32'hA0 + 32'(grp*16 + ph - 1), ph == 2);
            end
         end
         advance();
      end
      apply();
      n_vec++; if (pkt_cnt !== 4'd4) begin n_err++; $display("FAIL rr_pkt_cnt got %0d want 4", pkt_cnt); end
   endtask

   task automatic test_fairness_wrap();
      int          ev[10] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
      int          es[10] = '{0, 1, 1, 0, 3, 0, 0, 0, 3, 0};
      logic [31:0] ed[10] = '{0, 32'hB0, 32'hB1, 0, 32'hD0, 0, 32'hA0, 0, 32'hD1, 0};
      int          el[10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
      do_reset();
      len[1] = 2; plen[1] = 2;
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin len[0] = 1; len[3] = 2; plen[3] = 1; end
         apply();
         n_vec++; if (m_valid !== ev[k][0]) begin
            n_err++; $display("FAIL fair_valid c%0d got %b want %0d", k, m_valid, ev[k]);
         end
         if (ev[k] != 0) begin
            n_vec++;
            if (m_src !== 2'(es[k]) || m_data !== ed[k] || m_last !== el[k][0]) begin
               n_err++; $display("FAIL fair_beat c%0d got src=%0d data=%h last=%b want %0d/%h/%0d",
                  k, m_src, m_data, m_last, es[k], ed[k], el[k]);
            end
         end
         advance();
      end
      apply();
      n_vec++; if (pkt_cnt !== 4'd4) begin n_err++; $display("FAIL fair_pkt_cnt got %0d want 4", pkt_cnt); end
   endtask

   task automatic test_backpressure();
      int          ev[13] = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
      int          eb[13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
      logic [3:0]  er[13] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
      int          es[13] = '{0, 2, 2, 2, 2, 2, 2, 0, 0, 2, 2, 0, 1};
      logic [31:0] ed[13] = '{0, 32'hC0, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 0, 0,
                              32'hC1, 32'hC2, 0, 32'hB0};
      int          el[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
      do_reset();
      len[2] = 3; plen[2] = 3;
      for (int k = 0; k < 13; k++) begin
         if (k == 1) len[1] = 1;
         m_ready = !(k >= 2 && k <= 6);
         hold[2] = (k == 7 || k == 8);
         apply();
         n_vec++;
         if (m_valid !== ev[k][0] || busy !== eb[k][0] || s_ready !== er[k]) begin
            n_err++; $display("FAIL bp_ctrl c%0d got v=%b b=%b rdy=%b want %0d/%0d/%b",
               k, m_valid, busy, s_ready, ev[k], eb[k], er[k]);
         end
         if (ev[k] != 0) begin
            n_vec++;
            if (m_src !== 2'(es[k]) || m_data !== ed[k] || m_last !== el[k][0]) begin
               n_err++; $display("FAIL bp_beat c%0d got src=%0d data=%h last=%b want %0d/%h/%0d",
                  k, m_src, m_data, m_last, es[k], ed[k], el[k]);
            end
         end
         advance();
      end
      m_ready = 1'b1;
   endtask

   task automatic test_reset_mid_packet();
      int          ev[5] = '{0, 1, 0, 1, 1};
      int          es[5] = '{0, 2, 0, 1, 1};
      logic [31:0] ed[5] = '{0, 32'hC0, 0, 32'hB0, 32'hB1};
      do_reset();
      len[2] = 1;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin len[1] = 4; plen[1] = 4; end
         apply();
         n_vec++;
         if (m_valid !== ev[k][0] || (ev[k] != 0 && (m_src !== 2'(es[k]) || m_data !== ed[k]))) begin
            n_err++; $display("FAIL rstmid_beat c%0d got v=%b src=%0d data=%h want %0d/%0d/%h",
               k, m_valid, m_src, m_data, ev[k], es[k], ed[k]);
         end
         if (k < 4) advance();
      end
      n_vec++; if (pkt_cnt !== 4'd1) begin n_err++; $display("FAIL rstmid_cnt_pre got %0d want 1", pkt_cnt); end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (m_valid !== 1'b0 || s_ready !== 4'b0000 || busy !== 1'b0 || pkt_cnt !== 4'd0 ||
          m_src !== 2'd0 || m_last !== 1'b0 || m_data !== 32'h0) begin
         n_err++; $display("FAIL rstmid_async got v=%b rdy=%b b=%b cnt=%0d src=%0d last=%b data=%h want all 0",
            m_valid, s_ready, busy, pkt_cnt, m_src, m_last, m_data);
      end
      clear_model();
      len[1] = 1;
      len[3] = 1;
      @(negedge clk);
      rst_n = 1'b1;
      apply();
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_rel_idle got v=%b want 0", m_valid); end
      advance();
      apply();
      n_vec++; if (m_valid !== 1'b1 || m_src !== 2'd1) begin
         n_err++; $display("FAIL rstmid_ptr0 got v=%b src=%0d want 1/1", m_valid, m_src);
      end
      advance();
   endtask

   task automatic test_cnt_wrap();
      do_reset();
      len[0] = 17; plen[0] = 1;
      for (int k = 0; k < 34; k++) begin
         apply();
         if (k % 2 == 0) begin
            n_vec++;
            if (busy !== 1'b0 || m_valid !== 1'b0 || pkt_cnt !== 4'((k / 2) % 16)) begin
               n_err++; $display("FAIL wrap_idle c%0d got b=%b v=%b cnt=%0d want 0/0/%0d",
                  k, busy, m_valid, pkt_cnt, (k / 2) % 16);
            end
         end else begin
            n_vec++;
            if (busy !== 1'b1 || m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== 32'hA0 + 32'(k / 2)) begin
               n_err++; $display("FAIL wrap_busy c%0d got b=%b v=%b last=%b data=%h want 1/1/1/%h",
                  k, busy, m_valid, m_last, m_data, 32'hA0 + 32'(k / 2));
            end
         end
         advance();
      end
      apply();
      n_vec++; if (pkt_cnt !== 4'd1 || busy !== 1'b0) begin
         n_err++; $display("FAIL wrap_final got cnt=%0d b=%b want 1/0", pkt_cnt, busy);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      m_ready = 1'b1;
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_fairness_wrap();
      test_backpressure();
      test_reset_mid_packet();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
